mat_mul_host_port: RTL and testbench
====================================

# mat_mul_host_port

Host-side companion to the RISC-V matrix-multiply top. It streams matrix1 and matrix2 into data memory over a valid/ready input, holds the CPU in reset until loading is complete, then releases it and counts run cycles. When the CPU signals `done`, it reads the M×N2 result region back out of data memory and emits it on a valid/ready output stream. It sits between an external host (UART/JTAG bridge, or a bench) and the data-memory port mux in front of `D_Memory`.

## Interface
- `M`, 20, rows of matrix1
- `N`, 20, columns of matrix1 / rows of matrix2
- `N2`, 20, columns of matrix2
- `DATA_W`, 32, word width
- `ADDR_W`, 11, data-memory word-address width; must satisfy 2^ADDR_W ≥ M*N+N*N2+M*N2
- `CLOCK_50`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid` / `in_ready` / `in_data`  in / out / in  1 / 1 / DATA_W  matrix load stream
- `out_valid` / `out_ready` / `out_data` / `out_last`  out / in / out / out  1 / 1 / DATA_W / 1  result stream
- `mem_sel`  out  1  1 = this block drives the data-memory port; 0 = the CPU drives it
- `mem_we`  out  1  write enable
- `mem_addr`  out  ADDR_W  word address
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  read data; synchronous, valid 1 cycle after address
- `cpu_rstn`  out  1  active-low CPU reset
- `cpu_done`  in  1  CPU program-complete level
- `run_cycles`  out  32  cycles spent in RUN

## Operation
- Constants:
  - LD_WORDS = M*N+N*N2.
  - RES_BASE = LD_WORDS.
  - RES_WORDS = M*N2.
- States: IDLE → LOAD → RUN → DRAIN_RD ⇄ DRAIN_OUT → HOLD.
- **IDLE:** entered on reset. Advances unconditionally to LOAD on the next edge.
- **LOAD:**
  - `in_ready`=1.
  - Combinational write path: `mem_we` = `in_valid`; `mem_addr` = `ld_cnt`; `mem_wdata` = `in_data`.
  - Each accepted word increments `ld_cnt`.
  - On acceptance of word LD_WORDS-1, go to RUN.
- **RUN:**
  - `mem_sel`=0, `mem_we`=0, `in_ready`=0.
  - `run_cycles` increments every cycle and saturates at 0xFFFFFFFF.
  - `done_q` is a register that samples `cpu_done` every cycle in all states.
  - A rising edge (`cpu_done` & ~`done_q`) moves to DRAIN_RD with `rd_cnt`=0. A level that is already high does not trigger the move.
- **DRAIN_RD:** `mem_addr` = RES_BASE+`rd_cnt`; go to DRAIN_OUT next edge.
- **DRAIN_OUT:**
  - `mem_addr` is held at the same value.
  - `out_valid`=1; `out_data` = `mem_rdata`, combinational.
  - `out_last` = (`rd_cnt`==RES_WORDS-1).
  - On `out_valid` & `out_ready`: if last, go to HOLD; else `rd_cnt`++ and go to DRAIN_RD.
- **HOLD:** terminal state. All handshakes deasserted, `cpu_rstn` stays 1, `run_cycles` frozen. Only `rst` exits HOLD.
- `mem_sel`=1 in every state except RUN. `mem_we`=0 outside LOAD.
- `in_valid` outside LOAD is ignored: no write, no counter change.
- `cpu_rstn` is registered: 1 iff the registered state is RUN, DRAIN_*, or HOLD.

## Timing
- **Reset values:**
  - state=IDLE; `ld_cnt`=`rd_cnt`=0; `done_q`=0.
  - `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0 (gated by `out_valid`).
  - `mem_sel`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_rstn`=0, `run_cycles`=0.
- **Load ramp:** first `in_ready`=1 is in the 2nd cycle after `rst` deasserts.
- **Load throughput:** 1 word/cycle.
- **RUN entry:** `cpu_rstn` rises on the edge that accepts the last load word.
- **Done to output:**
  - Edge E detects the `cpu_done` rise.
  - Address is driven after E and latched by memory at E+1.
  - `out_valid`=1 in the cycle after E+1.
- **Drain throughput:** 2 cycles/word with `out_ready` held high.
- **Backpressure:** `out_data`/`out_last` stay stable while `out_valid` & ~`out_ready`, because the address is held.
- **`run_cycles`:** counts cycles whose sampled state is RUN, including the detection cycle.
- **`rst` mid-operation:** immediate return to reset values. Memory contents are untouched, and `cpu_rstn` drops asynchronously.

## Test plan
Unless noted, scenarios use M=N=N2=2: LD_WORDS=8, RES_BASE=8, RES_WORDS=4.
1. **Load:** stream words 1..8 with `in_valid` always high → writes at addresses 0..7 on 8 consecutive cycles; `cpu_rstn` rises after the 8th; `in_ready`=0 thereafter.
2. **Drain:** preload mem[8..11]={19,22,43,50}; pulse `cpu_done` 30 cycles after `cpu_rstn` rises → `out_data` sequence 19,22,43,50; `out_last` only on 50; `run_cycles`=30 at HOLD.
3. **Drain backpressure:** `out_ready` toggles 1,0,0,1,… → no word lost or duplicated; `out_data` stable while stalled.
4. **Load gaps and ignored input:** `in_valid` low for 3 cycles mid-load → `ld_cnt` pauses and addresses stay contiguous. Then assert `in_valid` during RUN → `mem_we` stays 0.
5. **Reset mid-drain:** assert `rst` after 2 words are output → `out_valid`=0 and `cpu_rstn`=0 immediately; after release, a full reload and run again produces all 4 words.
6. **Done level without edge:** hold `cpu_done`=1 from before RUN → the block stays in RUN and `run_cycles` keeps incrementing.

Source files
------------

// File: rtl/mat_mul_host_port.sv
// mat_mul_host_port: host-side loader/drainer for the matrix-multiply core.
// Loads both operands, releases the CPU, counts run cycles, drains results.
module mat_mul_host_port #(
    parameter int M      = 20,
    parameter int N      = 20,
    parameter int N2     = 20,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rstn,
    input  logic              cpu_done,
    output logic [31:0]       run_cycles
);

    localparam int LD_WORDS  = M * N + N * N2;
    localparam int RES_BASE  = LD_WORDS;
    localparam int RES_WORDS = M * N2;

    localparam logic [ADDR_W-1:0] LD_LAST  = ADDR_W'(LD_WORDS - 1);
    localparam logic [ADDR_W-1:0] RES_LAST = ADDR_W'(RES_WORDS - 1);
    localparam logic [ADDR_W-1:0] RES_BA   = ADDR_W'(RES_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN_RD,
        S_DRAIN_OUT,
        S_HOLD
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ld_cnt_q;
    logic [ADDR_W-1:0] rd_cnt_q;
    logic              done_q;
    logic              cpu_rstn_q;
    logic [31:0]       run_cycles_q;
    logic [31:0]       run_cycles_d;

    logic is_load;
    logic is_run;
    logic ld_last;
    logic rd_last;
    logic done_rise;

    assign is_load   = (state_q == S_LOAD);
    assign is_run    = (state_q == S_RUN);
    assign ld_last   = (ld_cnt_q == LD_LAST);
    assign rd_last   = (rd_cnt_q == RES_LAST);
    assign done_rise = cpu_done & ~done_q;

    assign in_ready   = is_load;
    assign out_valid  = (state_q == S_DRAIN_OUT);
    assign out_last   = out_valid & rd_last;
    assign out_data   = out_valid ? mem_rdata : '0;
    assign mem_sel    = ~is_run;
    assign mem_we     = is_load & in_valid;
    assign mem_wdata  = is_load ? in_data : '0;
    assign cpu_rstn   = cpu_rstn_q;
    assign run_cycles = run_cycles_q;

    // Saturating run counter so a hung program cannot wrap back to zero.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (run_cycles_q != '1) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    // Address mux: load pointer while loading, result pointer while draining.
    always_comb begin
        mem_addr = '0;
        unique case (state_q)
            S_LOAD:                  mem_addr = ld_cnt_q;
            S_DRAIN_RD, S_DRAIN_OUT: mem_addr = RES_BA + rd_cnt_q;
            default:                 mem_addr = '0;
        endcase
    end

    // Previous cpu_done level, so only a fresh rise ends the run.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= cpu_done;
        end
    end

    // Sequencer: load, run, drain one word per read/emit pair, then hold.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ld_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            cpu_rstn_q   <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        ld_cnt_q <= ld_cnt_q + 1'b1;
                        if (ld_last) begin
                            state_q    <= S_RUN;
                            cpu_rstn_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    run_cycles_q <= run_cycles_d;
                    if (done_rise) begin
                        state_q  <= S_DRAIN_RD;
                        rd_cnt_q <= '0;
                    end
                end
                S_DRAIN_RD: begin
                    state_q <= S_DRAIN_OUT;
                end
                S_DRAIN_OUT: begin
                    if (out_ready) begin
                        if (rd_last) begin
                            state_q <= S_HOLD;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 1'b1;
                            state_q  <= S_DRAIN_RD;
                        end
                    end
                end
                S_HOLD: begin
                    state_q <= S_HOLD;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mul_host_port.sv
// tb_mat_mul_host_port: directed/random bench for mat_mul_host_port.
// 2x2x2 matrices; bench models the memory, the CPU and the product.
module tb_mat_mul_host_port;

    localparam int LD  = 8;
    localparam int RW  = 4;
    localparam int RB  = 8;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        mem_sel;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        cpu_rstn;
    logic        cpu_done = 1'b0;
    logic [31:0] run_cycles;

    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;

    logic [31:0] mem [16];
    logic [3:0]  wlog_a[$];
    logic [31:0] wlog_d[$];

    int tests = 0;
    int fails = 0;

    mat_mul_host_port #(
        .M(2), .N(2), .N2(2), .DATA_W(32), .ADDR_W(4)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .mem_sel   (mem_sel),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_rstn  (cpu_rstn),
        .cpu_done  (cpu_done),
        .run_cycles(run_cycles)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Data memory behind the host/CPU port mux, synchronous read.
    always @(posedge CLOCK_50) begin
        if (mem_sel) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wlog_a.push_back(mem_addr);
                wlog_d.push_back(mem_wdata);
            end
            mem_rdata <= mem[mem_addr];
        end else begin
            if (cpu_we) mem[cpu_addr] <= cpu_wdata;
            mem_rdata <= mem[cpu_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    function automatic void matmul(input logic [31:0] w[LD],
                                   output logic [31:0] r[RW]);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                logic [31:0] s;
                s = 0;
                for (int k = 0; k < 2; k++) begin
                    s += w[i*2+k] * w[4+k*2+j];
                end
                r[i*2+j] = s;
            end
        end
    endfunction

    task automatic do_reset();
        tick();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cpu_we = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mem_sel", mem_sel, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rstn", cpu_rstn, 0);
        check("rst_run_cycles", run_cycles, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ramp_cycle1", in_ready, 0);
        tick();
        #1;
        check("ramp_cycle2", in_ready, 1);
    endtask

    task automatic load(input logic [31:0] w[LD], input int gap_at);
        int idx = 0;
        int cyc = 0;
        int base = wlog_a.size();
        logic v;
        while (idx < LD && cyc < 100) begin
            tick();
            v = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 3);
            in_valid = v;
            in_data = w[idx];
            #1;
            check("ld_ready", in_ready, 1);
            check("ld_we", mem_we, v);
            if (v) check("ld_addr", mem_addr, idx);
            if (v && in_ready) idx++;
            cyc++;
        end
        check("ld_done", idx, LD);
        check("ld_cycles", cyc, (gap_at >= 0) ? LD + 3 : LD);
        tick();
        in_valid = 1'b0;
        #1;
        check("ld_cpu_rstn", cpu_rstn, 1);
        check("ld_in_ready_off", in_ready, 0);
        check("run_mem_sel", mem_sel, 0);
        check("run_cnt0", run_cycles, 0);
        check("ld_nwrites", wlog_a.size() - base, LD);
        for (int i = 0; i < LD; i++) begin
            check("ld_log_addr", wlog_a[base+i], i);
            check("ld_log_data", wlog_d[base+i], w[i]);
        end
    endtask

    // k cycles of RUN, then a one-cycle cpu_done pulse detected on edge k+1.
    task automatic run(input int k, input logic [31:0] r[RW]);
        int base = wlog_a.size();
        for (int j = 1; j <= k; j++) begin
            tick();
            cpu_we = (j <= RW);
            cpu_addr = 4'(RB + ((j - 1) % RW));
            cpu_wdata = r[(j - 1) % RW];
            in_valid = (j == 6);
            cpu_done = (j == k);
            #1;
            if (j == 6) check("run_ignore_we", mem_we, 0);
            if (j == 10) check("run_cnt10", run_cycles, 10);
        end
        tick();
        cpu_we = 1'b0;
        in_valid = 1'b0;
        cpu_done = 1'b0;
        #1;
        check("rd_out_valid", out_valid, 0);
        check("rd_addr", mem_addr, RB);
        check("rd_run_cycles", run_cycles, k + 1);
        check("run_no_host_wr", wlog_a.size() - base, 0);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
    task automatic drain(input logic [31:0] r[RW], input int mode,
                         input int stop_after);
        int n = 0;
        int c = 0;
        int target = (stop_after > 0) ? stop_after : RW;
        logic stall = 1'b0;
        logic [31:0] pd = '0;
        while (n < target && c < 60) begin
            tick();
            out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            #1;
            if (c == 0) check("first_valid", out_valid, 1);
            if (stall) check("stall_valid", out_valid, 1);
            if (stall) check("stall_data", out_data, pd);
            if (out_valid) begin
                check("drain_data", out_data, r[n]);
                check("drain_last", out_last, n == RW - 1);
            end
            stall = out_valid & ~out_ready;
            pd = out_data;
            if (out_valid && out_ready) n++;
            c++;
        end
        check("drain_count", n, target);
        if (mode == 0 && stop_after == 0) check("drain_cycles", c, 7);
    endtask

    task automatic hold(input logic [31:0] exp_cycles);
        for (int j = 0; j < 4; j++) begin
            tick();
            out_ready = 1'b1;
            in_valid = 1'b1;
            cpu_done = (j == 1);
            #1;
            check("hold_out_valid", out_valid, 0);
            check("hold_out_last", out_last, 0);
            check("hold_in_ready", in_ready, 0);
            check("hold_we", mem_we, 0);
            check("hold_cpu_rstn", cpu_rstn, 1);
            check("hold_mem_sel", mem_sel, 1);
            check("hold_run_cycles", run_cycles, exp_cycles);
        end
        in_valid = 1'b0;
        cpu_done = 1'b0;
    endtask

    initial begin
        logic [31:0] w[LD];
        logic [31:0] r[RW];
        int k;

        // Scenario: fixed load 1..8, product {19,22,43,50}, 30 run cycles.
        do_reset();
        for (int i = 0; i < LD; i++) w[i] = i + 1;
        matmul(w, r);
        check("model_sanity", r[3], 50);
        load(w, -1);
        run(29, r);
        drain(r, 0, 0);
        hold(30);

        // Scenario: random operands, load gap, drain backpressure.
        do_reset();
        for (int i = 0; i < LD; i++) w[i] = $urandom_range(0, 255);
        matmul(w, r);
        k = $urandom_range(10, 40);
        load(w, 3);
        run(k, r);
        drain(r, 1, 0);
        hold(k + 1);

        // Scenario: reset after two output words, then full rerun.
        do_reset();
        for (int i = 0; i < LD; i++) w[i] = $urandom;
        matmul(w, r);
        load(w, -1);
        run(12, r);
        drain(r, 0, 2);
        do_reset();
        for (int i = 0; i < LD; i++) w[i] = $urandom_range(0, 1000);
        matmul(w, r);
        load(w, $urandom_range(0, 4));
        run(15, r);
        drain(r, 1, 0);
        hold(16);

        // Scenario: cpu_done already high before RUN never ends the run.
        do_reset();
        cpu_done = 1'b1;
        load(w, -1);
        for (int j = 1; j <= 40; j++) begin
            tick();
            #1;
            if (j % 10 == 0) begin
                check("lvl_run_cycles", run_cycles, j);
                check("lvl_out_valid", out_valid, 0);
                check("lvl_mem_sel", mem_sel, 0);
            end
        end
        cpu_done = 1'b0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
